// File: rtl/inst_fetch.sv
// inst_fetch: MIPS32 IF stage; owns the PC, fetches over an SRAM-like bus, presents the word to IF/ID
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        adel_o,
  output logic        stallreq_from_if
);
  typedef enum logic [1:0] {REQ, WAIT, DISCARD, DONE} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ibuf_q, ibuf_d, br_target_q, br_target_d, next_pc;
  logic br_pending_q, br_pending_d, pc_mis;
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};
  assign pc_mis = |pc_q[1:0];
  assign inst_req = state_q == REQ && !pc_mis;
  assign inst_addr = pc_q;
  assign pc_o = pc_q;
  assign inst_o = state_q == DONE && !pc_mis ? ibuf_q : '0;
  assign adel_o = state_q == DONE && pc_mis;
  assign stallreq_from_if = state_q != DONE;
  // a branch resolving in the advance cycle is taken directly instead of being parked
  assign next_pc = branch_flag_i ? branch_target_i : br_pending_q ? br_target_q : pc_q + 32'd4;
  // next-state, PC, fetch buffer and pending-branch logic; flush overrides normal progress
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ibuf_d = ibuf_q;
    br_pending_d = br_pending_q;
    br_target_d = br_target_q;
    if (branch_flag_i) begin
      br_pending_d = 1'b1;
      br_target_d = branch_target_i;
    end
    if (flush) begin
      pc_d = new_pc;
      br_pending_d = 1'b0;
      case (state_q)
        REQ:           state_d = inst_req && inst_addr_ok ? DISCARD : REQ;
        WAIT, DISCARD: state_d = inst_data_ok ? REQ : DISCARD;
        default:       state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ:     state_d = pc_mis ? DONE : inst_addr_ok ? WAIT : REQ;
        WAIT: begin
          state_d = inst_data_ok ? DONE : WAIT;
          ibuf_d = inst_data_ok ? inst_rdata : ibuf_q;
        end
        DISCARD: state_d = inst_data_ok ? REQ : DISCARD;
        default: if (!stall[1]) begin
          state_d = REQ;
          pc_d = next_pc;
          br_pending_d = 1'b0;
        end
      endcase
    end
    if (state_d == REQ && |pc_d[1:0]) state_d = DONE;
  end
  // state and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      ibuf_q <= '0;
      br_pending_q <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ibuf_q <= ibuf_d;
      br_pending_q <= br_pending_d;
      br_target_q <= br_target_d;
    end
  end
endmodule
